// File: rtl/comparator_checker.sv
// Exhaustive self-checker for a 2-bit-coded magnitude comparator.
// Sweeps every operand pair, holds each for SETTLE cycles, then scores the result.
module comparator_checker #(
    parameter int WIDTH  = 3,
    parameter bit SIGNED = 1'b0,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] num_1,
    output logic [WIDTH-1:0] num_2,
    input  logic [1:0]       result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_num_1,
    output logic [WIDTH-1:0] first_err_num_2,
    output logic [1:0]       first_err_result
);

    localparam logic [WIDTH-1:0] ALL_ONES    = '1;
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

    localparam logic [1:0] CODE_EQUAL   = 2'b00;
    localparam logic [1:0] CODE_LARGER  = 2'b01;
    localparam logic [1:0] CODE_SMALLER = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic [1:0] expected;
    logic       mismatch;
    logic       last_pair;
    logic       settled;
    logic       accept;

    always_comb begin
        expected = CODE_EQUAL;
        if (SIGNED) begin
            if ($signed(num_1) > $signed(num_2)) begin
                expected = CODE_LARGER;
            end else if ($signed(num_1) < $signed(num_2)) begin
                expected = CODE_SMALLER;
            end
        end else begin
            if (num_1 > num_2) begin
                expected = CODE_LARGER;
            end else if (num_1 < num_2) begin
                expected = CODE_SMALLER;
            end
        end
    end

    assign mismatch  = (result != expected);
    assign last_pair = (num_1 == ALL_ONES) && (num_2 == ALL_ONES);
    assign settled   = (settle_cnt == SETTLE_LAST);
    // Only an idle or finished checker can be restarted.
    assign accept    = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (settled) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = last_pair ? DONE : DRIVE;
            end
            DONE: begin
                if (start) begin
                    state_next = DRIVE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt       <= '0;
            num_1            <= '0;
            num_2            <= '0;
            err_count        <= '0;
            first_err_valid  <= 1'b0;
            first_err_num_1  <= '0;
            first_err_num_2  <= '0;
            first_err_result <= '0;
        end else if (accept) begin
            settle_cnt       <= '0;
            num_1            <= '0;
            num_2            <= '0;
            err_count        <= '0;
            first_err_valid  <= 1'b0;
            first_err_num_1  <= '0;
            first_err_num_2  <= '0;
            first_err_result <= '0;
        end else begin
            case (state)
                DRIVE: begin
                    settle_cnt <= settled ? 4'd0 : settle_cnt + 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (!first_err_valid) begin
                            first_err_valid  <= 1'b1;
                            first_err_num_1  <= num_1;
                            first_err_num_2  <= num_2;
                            first_err_result <= result;
                        end
                    end
                    // Operands freeze on the final pair.
                    if (num_2 != ALL_ONES) begin
                        num_2 <= num_2 + 1'b1;
                    end else if (num_1 != ALL_ONES) begin
                        num_2 <= '0;
                        num_1 <= num_1 + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == DRIVE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_comparator_checker.sv
// Bench for comparator_checker: three instances (default, signed, slow settle)
// scored against a pair-by-pair reference sweep.
module tb_comparator_checker;

    localparam int W = 3;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    logic            start_v  [3];
    logic [W-1:0]    n1_v     [3];
    logic [W-1:0]    n2_v     [3];
    logic [1:0]      res_v    [3];
    logic            busy_v   [3];
    logic            done_v   [3];
    logic            pass_v   [3];
    logic [15:0]     err_v    [3];
    logic            fv_v     [3];
    logic [W-1:0]    fn1_v    [3];
    logic [W-1:0]    fn2_v    [3];
    logic [1:0]      fres_v   [3];
    int              mode_v   [3];
    int              fx;
    int              fy;
    logic [1:0]      fc;
    int              n_checks;
    int              n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    comparator_checker #(.WIDTH(W), .SIGNED(1'b0), .SETTLE(1)) u_def (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .num_1(n1_v[0]), .num_2(n2_v[0]), .result(res_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .first_err_valid(fv_v[0]),
        .first_err_num_1(fn1_v[0]), .first_err_num_2(fn2_v[0]),
        .first_err_result(fres_v[0])
    );

    comparator_checker #(.WIDTH(W), .SIGNED(1'b1), .SETTLE(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .num_1(n1_v[1]), .num_2(n2_v[1]), .result(res_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .first_err_valid(fv_v[1]),
        .first_err_num_1(fn1_v[1]), .first_err_num_2(fn2_v[1]),
        .first_err_result(fres_v[1])
    );

    comparator_checker #(.WIDTH(W), .SIGNED(1'b0), .SETTLE(3)) u_slow (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .num_1(n1_v[2]), .num_2(n2_v[2]), .result(res_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(err_v[2]), .first_err_valid(fv_v[2]),
        .first_err_num_1(fn1_v[2]), .first_err_num_2(fn2_v[2]),
        .first_err_result(fres_v[2])
    );

    function automatic logic [1:0] exp_code(int a, int b, bit sgn);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (sgn) begin
            if (sa >= N / 2) sa -= N;
            if (sb >= N / 2) sb -= N;
        end
        if (sa > sb) return 2'b01;
        if (sa < sb) return 2'b10;
        return 2'b00;
    endfunction

    // mode 0: correct unsigned, 1: one faulty pair, 2: stuck at illegal code
    function automatic logic [1:0] comp_model(int mode, int a, int b,
                                              int x, int y, logic [1:0] c);
        if (mode == 2) return 2'b11;
        if (mode == 1 && a == x && b == y) return c;
        return exp_code(a, b, 1'b0);
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            res_v[i] = comp_model(mode_v[i], int'(n1_v[i]), int'(n2_v[i]),
                                  fx, fy, fc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int w, input int restart, output int cycles);
        logic [5:0] seen [$];
        logic [5:0] cur;
        int bad;
        start_v[w] = 1'b1;
        @(posedge clk);
        #1;
        start_v[w] = 1'b0;
        cycles = 0;
        while (busy_v[w] && cycles < 4000) begin
            cycles++;
            cur = {n1_v[w], n2_v[w]};
            if (seen.size() == 0 || seen[$] != cur) seen.push_back(cur);
            start_v[w] = (cycles == restart);
            @(posedge clk);
            #1;
        end
        start_v[w] = 1'b0;
        check("bounded", 32'(cycles < 4000), 32'd1);
        bad = (seen.size() == N * N) ? 0 : 1;
        foreach (seen[i]) begin
            if (int'(seen[i]) != i) bad++;
        end
        check("order", 32'(bad), 32'd0);
    endtask

    task automatic verify(input int w, input bit sgn, input int settle,
                          input int restart, input string p);
        int errs;
        bit fvx;
        int f1;
        int f2;
        logic [1:0] fr;
        logic [1:0] r;
        int cycles;
        errs = 0;
        fvx = 1'b0;
        f1 = 0;
        f2 = 0;
        fr = 2'b00;
        for (int a = 0; a < N; a++) begin
            for (int b = 0; b < N; b++) begin
                r = comp_model(mode_v[w], a, b, fx, fy, fc);
                if (r != exp_code(a, b, sgn)) begin
                    errs++;
                    if (!fvx) begin
                        fvx = 1'b1;
                        f1 = a;
                        f2 = b;
                        fr = r;
                    end
                end
            end
        end
        run(w, restart, cycles);
        check({p, "_len"}, 32'(cycles), 32'(N * N * (settle + 1)));
        check({p, "_done"}, 32'(done_v[w]), 32'd1);
        check({p, "_busy"}, 32'(busy_v[w]), 32'd0);
        check({p, "_pass"}, 32'(pass_v[w]), 32'(errs == 0));
        check({p, "_err"}, 32'(err_v[w]), 32'(errs));
        check({p, "_fv"}, 32'(fv_v[w]), 32'(fvx));
        check({p, "_fn1"}, 32'(fn1_v[w]), 32'(f1));
        check({p, "_fn2"}, 32'(fn2_v[w]), 32'(f2));
        check({p, "_fres"}, 32'(fres_v[w]), 32'(fr));
        check({p, "_n1"}, 32'(n1_v[w]), 32'(N - 1));
        check({p, "_n2"}, 32'(n2_v[w]), 32'(N - 1));
        @(posedge clk);
        #1;
        check({p, "_hold"}, 32'(done_v[w]), 32'd1);
    endtask

    task automatic check_reset(input int w, input string p);
        check({p, "_busy"}, 32'(busy_v[w]), 32'd0);
        check({p, "_done"}, 32'(done_v[w]), 32'd0);
        check({p, "_pass"}, 32'(pass_v[w]), 32'd0);
        check({p, "_err"}, 32'(err_v[w]), 32'd0);
        check({p, "_fv"}, 32'(fv_v[w]), 32'd0);
        check({p, "_n1"}, 32'(n1_v[w]), 32'd0);
        check({p, "_n2"}, 32'(n2_v[w]), 32'd0);
        check({p, "_fn1"}, 32'(fn1_v[w]), 32'd0);
        check({p, "_fn2"}, 32'(fn2_v[w]), 32'd0);
        check({p, "_fres"}, 32'(fres_v[w]), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        fx = 0;
        fy = 0;
        fc = 2'b00;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset(0, "rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // clean sweep; a start on the final CHECK cycle must be dropped
        verify(0, 1'b0, 1, N * N * 2, "clean");

        mode_v[0] = 1;
        fx = 3;
        fy = 5;
        fc = 2'b00;
        verify(0, 1'b0, 1, 0, "pair35");

        for (int k = 0; k < 6; k++) begin
            fx = int'($urandom_range(N - 1, 0));
            fy = int'($urandom_range(N - 1, 0));
            fc = 2'($urandom_range(3, 0));
            repeat ($urandom_range(4, 0)) @(posedge clk);
            #1;
            verify(0, 1'b0, 1, int'($urandom_range(N * N * 2, 0)), "rnd");
        end

        mode_v[0] = 2;
        verify(0, 1'b0, 1, 0, "stuck");

        mode_v[1] = 0;
        verify(1, 1'b1, 1, 0, "signed");

        mode_v[2] = 0;
        verify(2, 1'b0, 3, 10, "slow");

        // abort mid-sweep, then restart on the first cycle out of reset
        mode_v[0] = 2;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset(0, "abort");
        rst_n = 1'b1;
        mode_v[0] = 0;
        verify(0, 1'b0, 1, 0, "after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
